// File: rtl/vram_console.sv
// vram_console: text-mode terminal that writes characters into VGA video RAM.
// Define VRAM_CONSOLE_SCROLL_EN to scroll on bottom-row overflow; otherwise the cursor wraps to row 0.
module vram_console #(
    parameter int         COLS         = 80,
    parameter int         ROWS         = 25,
    parameter int         ADDR_W       = 12,
    parameter logic [7:0] DEFAULT_ATTR = 8'h07
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    char_valid_i,
    input  logic [7:0]              char_data_i,
    output logic                    char_ready_o,
    input  logic [7:0]              attr_i,
    input  logic                    clear_req_i,
    output logic [ADDR_W-1:0]       vram_addr_o,
    output logic [15:0]             vram_wdata_o,
    output logic                    vram_we_o,
    input  logic [15:0]             vram_rdata_i,
    output logic [$clog2(COLS)-1:0] cursor_col_o,
    output logic [$clog2(ROWS)-1:0] cursor_row_o,
    output logic                    busy_o
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0] CELLS      = CNT_W'(COLS * ROWS);
    localparam logic [CNT_W-1:0] ROW_CELLS  = CNT_W'(COLS);
    localparam logic [15:0]      BLANK_CELL = {DEFAULT_ATTR, 8'h00};
    localparam logic [15:0]      BS_CELL    = {DEFAULT_ATTR, 8'h20};
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
`ifdef VRAM_CONSOLE_SCROLL_EN
    localparam logic [ADDR_W-1:0] BLANK_BASE   = ADDR_W'(COLS * (ROWS - 1));
    localparam logic [CNT_W-1:0]  SCROLL_CELLS = CNT_W'(COLS * (ROWS - 1));
`else
    localparam logic [ADDR_W-1:0] BLANK_BASE   = '0;
`endif

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_PUT,
`ifdef VRAM_CONSOLE_SCROLL_EN
        ST_SCROLL_RD,
        ST_SCROLL_WR,
`endif
        ST_BLANK_ROW
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               ovf_q, ovf_d;
    logic               clr_pend_q, clr_pend_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               ready_q, ready_d;
    logic [ADDR_W-1:0]  cur_addr;
    logic               newline;
    logic               finish;
`ifdef VRAM_CONSOLE_SCROLL_EN
    logic               fwd_q, fwd_d;
`endif

    // Every bus output is registered: the value decided at an edge is what the RAM sees next cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        row_d      = row_q;
        ovf_d      = ovf_q;
        clr_pend_d = clr_pend_q | clear_req_i;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ready_d    = 1'b0;
        newline    = 1'b0;
        finish     = 1'b0;
`ifdef VRAM_CONSOLE_SCROLL_EN
        fwd_d      = 1'b0;
`endif
        cur_addr   = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

        case (state_q)
            ST_CLEAR: begin
                if (cnt_q < CELLS) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = BLANK_CELL;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    finish  = 1'b1;
                end
            end

            ST_IDLE: begin
                clr_pend_d = 1'b0;
                ready_d    = 1'b1;
                if (clear_req_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    ready_d = 1'b0;
                end else if (char_valid_i && ready_q) begin
                    ready_d = 1'b0;
                    state_d = ST_PUT;
                    ovf_d   = 1'b0;
                    addr_d  = cur_addr;
                    wdata_d = {attr_i, char_data_i};
                    if (char_data_i >= 8'h20 && char_data_i <= 8'h7E) begin
                        we_d = 1'b1;
                        if (col_q == LAST_COL) begin
                            col_d   = '0;
                            newline = 1'b1;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end else if (char_data_i == 8'h0D) begin
                        col_d = '0;
                    end else if (char_data_i == 8'h0A) begin
                        col_d   = '0;
                        newline = 1'b1;
                    end else if (char_data_i == 8'h08) begin
                        if (col_q != '0) begin
                            col_d   = col_q - COL_W'(1);
                            we_d    = 1'b1;
                            addr_d  = cur_addr - ADDR_W'(1);
                            wdata_d = BS_CELL;
                        end
                    end

                    if (newline) begin
                        if (row_q == LAST_ROW) begin
                            ovf_d = 1'b1;
`ifdef VRAM_CONSOLE_SCROLL_EN
                            row_d = row_q;
`else
                            row_d = '0;
`endif
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end
                end
            end

            ST_PUT: begin
                if (ovf_q) begin
                    ovf_d = 1'b0;
                    cnt_d = '0;
`ifdef VRAM_CONSOLE_SCROLL_EN
                    state_d = ST_SCROLL_RD;
`else
                    state_d = ST_BLANK_ROW;
`endif
                end else begin
                    finish = 1'b1;
                end
            end

`ifdef VRAM_CONSOLE_SCROLL_EN
            ST_SCROLL_RD: begin
                addr_d  = cnt_q[ADDR_W-1:0] + ADDR_W'(COLS);
                state_d = ST_SCROLL_WR;
            end

            // Read data arrives while the write is on the bus, so wdata is forwarded from vram_rdata.
            ST_SCROLL_WR: begin
                we_d   = 1'b1;
                addr_d = cnt_q[ADDR_W-1:0];
                fwd_d  = 1'b1;
                if (cnt_q == SCROLL_CELLS - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_BLANK_ROW;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_SCROLL_RD;
                end
            end
`endif

            ST_BLANK_ROW: begin
                if (cnt_q < ROW_CELLS) begin
                    we_d    = 1'b1;
                    addr_d  = BLANK_BASE + cnt_q[ADDR_W-1:0];
                    wdata_d = BLANK_CELL;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    finish  = 1'b1;
                end
            end

            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase

        // A clear requested while busy replaces the return to IDLE.
        if (finish) begin
            if (clr_pend_q || clear_req_i) begin
                state_d    = ST_CLEAR;
                cnt_d      = '0;
                col_d      = '0;
                row_d      = '0;
                clr_pend_d = 1'b0;
            end else begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            ovf_q      <= 1'b0;
            clr_pend_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
`ifdef VRAM_CONSOLE_SCROLL_EN
            fwd_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            row_q      <= row_d;
            ovf_q      <= ovf_d;
            clr_pend_q <= clr_pend_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
`ifdef VRAM_CONSOLE_SCROLL_EN
            fwd_q      <= fwd_d;
`endif
        end
    end

`ifdef VRAM_CONSOLE_SCROLL_EN
    assign vram_wdata_o = fwd_q ? vram_rdata_i : wdata_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^vram_rdata_i;
    assign vram_wdata_o = wdata_q;
`endif

    assign vram_addr_o  = addr_q;
    assign vram_we_o    = we_q;
    assign char_ready_o = ready_q;
    assign cursor_col_o = col_q;
    assign cursor_row_o = row_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule
